// File: rtl/warp_regfile_pkg.sv
// Shared types, default sizes and helpers for warp_regfile_mp and warp_regfile_lane.
package warp_regfile_pkg;

    localparam int NUM_LANES_DEF  = 8;
    localparam int NUM_WARPS_DEF  = 16;
    localparam int NUM_REGS_DEF   = 16;
    localparam int DATA_W_DEF     = 32;
    localparam int NUM_RPORTS_DEF = 2;

    // Widest word the parity helper accepts; narrower words are zero-extended.
    localparam int PARITY_MAX_W   = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_ok(input int idx, input int lim);
        return idx < lim;
    endfunction

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/warp_regfile_lane.sv
// One SIMD lane of the warp register file: 1 write port, NUM_RPORTS registered read ports
// with write/clear bypass. Optional stored parity under REGFILE_PARITY_EN.
module warp_regfile_lane
    import warp_regfile_pkg::*;
#(
    parameter int NUM_WARPS  = NUM_WARPS_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_RPORTS = NUM_RPORTS_DEF,
    localparam int WID_W     = idx_w(NUM_WARPS),
    localparam int RID_W     = idx_w(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we_i,
    input  logic [WID_W-1:0]             wwarp_i,
    input  logic [RID_W-1:0]             waddr_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic                         clr_we_i,
    input  logic [WID_W-1:0]             clr_warp_i,
    input  logic [RID_W-1:0]             clr_addr_i,
    input  logic [NUM_RPORTS-1:0]        re_i,
    input  logic [NUM_RPORTS*WID_W-1:0]  rwarp_i,
    input  logic [NUM_RPORTS*RID_W-1:0]  raddr_i,
    output logic [NUM_RPORTS*DATA_W-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]        par_err_o
);

    localparam int DEPTH = NUM_WARPS * NUM_REGS;
    localparam int AW    = idx_w(DEPTH);

    function automatic logic [AW-1:0] flat_idx(input logic [WID_W-1:0] w, input logic [RID_W-1:0] r);
        return AW'(int'(w) * NUM_REGS + int'(r));
    endfunction

    function automatic logic in_range(input logic [WID_W-1:0] w, input logic [RID_W-1:0] r);
        return idx_ok(int'(w), NUM_WARPS) && idx_ok(int'(r), NUM_REGS);
    endfunction

    logic          w_hit;
    logic          c_hit;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] c_idx;

    assign w_idx = flat_idx(wwarp_i, waddr_i);
    assign c_idx = flat_idx(clr_warp_i, clr_addr_i);
    assign w_hit = we_i && in_range(wwarp_i, waddr_i);
    assign c_hit = clr_we_i && in_range(clr_warp_i, clr_addr_i);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage is intentionally not reset so it can map onto RAM; the external write is
    // ordered after the clear write so it wins when both target the same word.
    always_ff @(posedge clk) begin
        if (c_hit) mem_q[c_idx] <= '0;
        if (w_hit) mem_q[w_idx] <= wdata_i;
    end

`ifdef REGFILE_PARITY_EN
    logic mem_par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (c_hit) mem_par_q[c_idx] <= 1'b0;
        if (w_hit) mem_par_q[w_idx] <= even_parity(PARITY_MAX_W'(wdata_i));
    end
`endif

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
        logic [WID_W-1:0]  rw;
        logic [RID_W-1:0]  ra;
        logic [AW-1:0]     r_idx;
        logic              r_ok;
        logic              w_fwd;
        logic              c_fwd;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign rw    = rwarp_i[p*WID_W +: WID_W];
        assign ra    = raddr_i[p*RID_W +: RID_W];
        assign r_idx = flat_idx(rw, ra);
        assign r_ok  = in_range(rw, ra);
        assign w_fwd = w_hit && (w_idx == r_idx);
        assign c_fwd = c_hit && (c_idx == r_idx);

        // Forwarding returns exactly what the word will hold after this edge.
        always_comb begin
            rd_d = '0;
            if (r_ok) begin
                if (w_fwd)      rd_d = wdata_i;
                else if (c_fwd) rd_d = '0;
                else            rd_d = mem_q[r_idx];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       rd_q <= '0;
            else if (re_i[p]) rd_q <= rd_d;
        end

        assign rdata_o[p*DATA_W +: DATA_W] = rd_q;

`ifdef REGFILE_PARITY_EN
        logic pe_d;
        logic pe_q;

        always_comb begin
            pe_d = 1'b0;
            if (r_ok && !w_fwd && !c_fwd)
                pe_d = mem_par_q[r_idx] ^ even_parity(PARITY_MAX_W'(rd_d));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       pe_q <= 1'b0;
            else if (re_i[p]) pe_q <= pe_d;
        end

        assign par_err_o[p] = pe_q;
`else
        assign par_err_o[p] = 1'b0;
`endif
    end

endmodule

// File: rtl/warp_regfile_mp.sv
// Multi-warp, multi-read-port SIMT register file with a warp-context clear sequencer.
// Optional per-word parity is enabled by defining REGFILE_PARITY_EN.
module warp_regfile_mp
    import warp_regfile_pkg::*;
#(
    parameter int NUM_LANES  = NUM_LANES_DEF,
    parameter int NUM_WARPS  = NUM_WARPS_DEF,
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_RPORTS = NUM_RPORTS_DEF,
    localparam int WID_W     = idx_w(NUM_WARPS),
    localparam int RID_W     = idx_w(NUM_REGS)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_RPORTS*NUM_LANES-1:0]        read_en,
    input  logic [NUM_RPORTS*WID_W-1:0]            rwarp,
    input  logic [NUM_RPORTS*RID_W-1:0]            raddr,
    output logic [NUM_RPORTS*NUM_LANES*DATA_W-1:0] rdata,
    input  logic [NUM_LANES-1:0]                   write_en,
    input  logic [WID_W-1:0]                       wwarp,
    input  logic [RID_W-1:0]                       waddr,
    input  logic [NUM_LANES*DATA_W-1:0]            wdata,
    input  logic                                   clear_req,
    input  logic [WID_W-1:0]                       clear_warp,
    output logic                                   clear_busy,
    output logic [NUM_RPORTS*NUM_LANES-1:0]        par_err
);

    clr_state_e       state_q, state_d;
    logic [RID_W-1:0] cnt_q, cnt_d;
    logic [WID_W-1:0] cwarp_q, cwarp_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cwarp_d = cwarp_q;
        unique case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    cwarp_d = clear_warp;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == RID_W'(NUM_REGS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cwarp_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cwarp_q <= cwarp_d;
        end
    end

    assign clear_busy = (state_q == CLEAR);

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [NUM_RPORTS-1:0]        re;
        logic [NUM_RPORTS*DATA_W-1:0] rd;
        logic [NUM_RPORTS-1:0]        pe;

        // External buses are port-major; each lane sees only its own slice of every port.
        for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
            assign re[p]                                       = read_en[p*NUM_LANES + l];
            assign rdata[(p*NUM_LANES + l)*DATA_W +: DATA_W]   = rd[p*DATA_W +: DATA_W];
            assign par_err[p*NUM_LANES + l]                    = pe[p];
        end

        warp_regfile_lane #(
            .NUM_WARPS  (NUM_WARPS),
            .NUM_REGS   (NUM_REGS),
            .DATA_W     (DATA_W),
            .NUM_RPORTS (NUM_RPORTS)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .we_i       (write_en[l]),
            .wwarp_i    (wwarp),
            .waddr_i    (waddr),
            .wdata_i    (wdata[l*DATA_W +: DATA_W]),
            .clr_we_i   (clear_busy),
            .clr_warp_i (cwarp_q),
            .clr_addr_i (cnt_q),
            .re_i       (re),
            .rwarp_i    (rwarp),
            .raddr_i    (raddr),
            .rdata_o    (rd),
            .par_err_o  (pe)
        );
    end

endmodule
